// File: rtl/alarm_timer.sv
// Countdown timer for the anti-theft controller: holds the four delay parameters,
// generates the 1 Hz tick and pulses expired once the selected delay has elapsed.
module alarm_timer #(
  parameter int CLK_FREQ            = 50_000_000,
  parameter int T_ARM_DEFAULT       = 6,
  parameter int T_DRIVER_DEFAULT    = 8,
  parameter int T_PASSENGER_DEFAULT = 15,
  parameter int T_ALARM_DEFAULT     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic [3:0] count_value
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_param [4];
  logic [DIV_W-1:0] r_div;
  logic             r_one_hz;
  logic             r_expired;
  logic [3:0]       r_count;
  logic             r_start_q;
  logic [1:0]       r_interval_q;

  logic             w_load;
  logic [DIV_W-1:0] w_div_next;

  assign w_load = start_timer && (!r_start_q || (interval != r_interval_q));

  // The tick is registered off the divider's next value, so it is high while the
  // divider sits at terminal count: the first tick lands CLK_FREQ cycles after a load.
  always_comb begin
    w_div_next = '0;
    if (!w_load && (r_div != DIV_TC)) begin
      w_div_next = r_div + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_param[0]   <= 4'(T_ARM_DEFAULT);
      r_param[1]   <= 4'(T_DRIVER_DEFAULT);
      r_param[2]   <= 4'(T_PASSENGER_DEFAULT);
      r_param[3]   <= 4'(T_ALARM_DEFAULT);
      r_div        <= '0;
      r_one_hz     <= 1'b0;
      r_expired    <= 1'b0;
      r_count      <= 4'd0;
      r_start_q    <= 1'b0;
      r_interval_q <= 2'b00;
    end else begin
      r_start_q    <= start_timer;
      r_interval_q <= interval;
      r_div        <= w_div_next;
      r_one_hz     <= (w_div_next == DIV_TC);
      r_expired    <= 1'b0;

      // A same-cycle load reads the old entry; the write lands for later loads.
      if (reprogram) begin
        r_param[time_param_sel] <= time_value;
      end

      if (!start_timer) begin
        r_state <= ST_IDLE;
        r_count <= 4'd0;
      end else if (w_load) begin
        r_state <= ST_COUNT;
        r_count <= r_param[interval];
      end else begin
        case (r_state)
          ST_COUNT: begin
            if (r_count == 4'd0) begin
              r_state   <= ST_DONE;
              r_expired <= 1'b1;
            end else if (r_one_hz) begin
              // Reaching zero and entering DONE share one edge to keep N*CLK_FREQ+1 latency.
              if (r_count == 4'd1) begin
                r_state   <= ST_DONE;
                r_expired <= 1'b1;
              end
              r_count <= r_count - 4'd1;
            end
          end
          ST_DONE: begin
            r_count <= 4'd0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
          end
        endcase
      end
    end
  end

  assign expired       = r_expired;
  assign one_hz_enable = r_one_hz;
  assign count_value   = r_count;

endmodule

// File: tb/tb_alarm_timer.sv
// Directed bench for alarm_timer at CLK_FREQ=4; expiry times are queued when a load is
// driven and popped when the expired pulse is observed.
module tb_alarm_timer;

  localparam int F = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'b00;
  logic [3:0] time_value = 4'd0;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] count_value;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_q[$];

  alarm_timer #(.CLK_FREQ(F)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .count_value    (count_value)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next expired pulse and compare its cycle to the queued expectation.
  task automatic expect_expiry(input string tag, input int budget);
    int obs;
    int exp;
    bit seen;
    obs = -1;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (expired) begin
        obs = cyc;
        seen = 1'b1;
      end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    check(tag, obs, exp);
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (expired) pulses++;
    end
  endtask

  task automatic wait_tick(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (one_hz_enable) seen = 1'b1;
    end
    check(tag, int'(seen), 1);
  endtask

  task automatic wait_count(input string tag, input int value, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (count_value == 4'(value)) seen = 1'b1;
    end
    check(tag, int'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int defaults [4];
    defaults = '{6, 8, 15, 10};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_count", int'(count_value), 0);
    check("reset_expired", int'(expired), 0);
    check("reset_one_hz", int'(one_hz_enable), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: driver delay, 8 s
    start_timer = 1'b1;
    interval = 2'b01;
    exp_q.push_back(cyc + 8 * F + 1);
    @(negedge clock);
    check("t1_load_count", int'(count_value), 8);
    expect_expiry("t1_expiry", 60);
    count_pulses(10, pulses);
    check("t1_no_repeat", pulses, 0);
    check("t1_done_count", int'(count_value), 0);

    // 2: interval change with start held high
    start_timer = 1'b0;
    @(negedge clock);
    start_timer = 1'b1;
    interval = 2'b01;
    wait_tick("t2_tick1", 10);
    wait_tick("t2_tick2", 10);
    check("t2_count_before", int'(count_value), 7);
    interval = 2'b11;
    exp_q.push_back(cyc + 10 * F + 1);
    @(negedge clock);
    check("t2_reload_count", int'(count_value), 10);
    expect_expiry("t2_expiry", 60);

    // 3: reprogram passenger delay to 3, then to 0
    start_timer = 1'b0;
    @(negedge clock);
    reprogram = 1'b1;
    time_param_sel = 2'd2;
    time_value = 4'd3;
    @(negedge clock);
    reprogram = 1'b0;
    start_timer = 1'b1;
    interval = 2'b10;
    exp_q.push_back(cyc + 3 * F + 1);
    @(negedge clock);
    check("t3_load_count", int'(count_value), 3);
    expect_expiry("t3_expiry", 30);
    start_timer = 1'b0;
    @(negedge clock);
    reprogram = 1'b1;
    time_value = 4'd0;
    @(negedge clock);
    reprogram = 1'b0;
    start_timer = 1'b1;
    exp_q.push_back(cyc + 2);
    @(negedge clock);
    check("t3_zero_count", int'(count_value), 0);
    expect_expiry("t3_zero_expiry", 10);

    // 4: abort mid-count, then full reload
    start_timer = 1'b0;
    @(negedge clock);
    start_timer = 1'b1;
    interval = 2'b01;
    wait_count("t4_reach5", 5, 30);
    start_timer = 1'b0;
    @(negedge clock);
    check("t4_abort_count", int'(count_value), 0);
    count_pulses(40, pulses);
    check("t4_no_expiry", pulses, 0);
    start_timer = 1'b1;
    exp_q.push_back(cyc + 8 * F + 1);
    @(negedge clock);
    check("t4_reload_count", int'(count_value), 8);
    expect_expiry("t4_expiry", 60);

    // 5: write to the entry being loaded in the same cycle
    start_timer = 1'b0;
    @(negedge clock);
    start_timer = 1'b1;
    interval = 2'b00;
    reprogram = 1'b1;
    time_param_sel = 2'd0;
    time_value = 4'd9;
    exp_q.push_back(cyc + 6 * F + 1);
    @(negedge clock);
    reprogram = 1'b0;
    check("t5_old_value", int'(count_value), 6);
    expect_expiry("t5_expiry", 40);
    start_timer = 1'b0;
    @(negedge clock);
    start_timer = 1'b1;
    exp_q.push_back(cyc + 9 * F + 1);
    @(negedge clock);
    check("t5_new_value", int'(count_value), 9);
    expect_expiry("t5_new_expiry", 50);

    // 6: asynchronous reset mid-count restores the table
    start_timer = 1'b0;
    @(negedge clock);
    start_timer = 1'b1;
    interval = 2'b01;
    repeat (6) @(negedge clock);
    check("t6_counting", int'(count_value), 7);
    #2 reset = 1'b1;
    #1;
    check("t6_async_count", int'(count_value), 0);
    check("t6_async_expired", int'(expired), 0);
    check("t6_async_one_hz", int'(one_hz_enable), 0);
    start_timer = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      start_timer = 1'b1;
      interval = 2'(i);
      @(negedge clock);
      check($sformatf("t6_default_%0d", i), int'(count_value), defaults[i]);
      start_timer = 1'b0;
      @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
